// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and load/store.
// Latency: grant and RAM command in the request cycle; read data returns RD_LATENCY cycles later.
// Backpressure: a request is held off (gnt low, halt high) while the port is busy or lost to the other requester.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    // instruction fetch requester (read only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    // load/store requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    // RAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    // pipeline freeze
    output logic              halt
);

    // Counters are 4 bits wide, so both limits are folded into that width once here.
    localparam logic [3:0] LAT_INIT  = 4'(RD_LATENCY);
    localparam logic [3:0] STARVE_AT = 4'(STARVE_LIMIT);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] lat_cnt;
    logic [3:0] lat_cnt_nxt;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_nxt;
    logic       owner;        // 0 = fetch owns the outstanding read, 1 = load/store
    logic       owner_nxt;

    logic       rd_done;      // outstanding read returns its data this cycle
    logic       arb_open;     // the RAM port can accept a new command this cycle
    logic       starve_hit;
    logic       if_win;
    logic       d_win;
    logic       rd_grant;

    // Arbitration: load/store wins unless fetch has lost STARVE_LIMIT contested grants in a row.
    // The return cycle of a read is also a free cycle, giving one read every RD_LATENCY cycles.
    always_comb begin
        rd_done    = (state == RD_WAIT) && (lat_cnt == 4'd1);
        arb_open   = rst_n && ((state == IDLE) || rd_done);
        starve_hit = (starve_cnt == STARVE_AT);
        if_win     = arb_open && if_req && (!d_req || starve_hit);
        d_win      = arb_open && d_req && !if_win;
        rd_grant   = if_win || (d_win && !d_we);
    end

    // Output decode: grants, RAM command, read-data steering and the core halt.
    // Everything is forced low while reset is asserted.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        halt      = 1'b0;
        if (rst_n) begin
            if_gnt = if_win;
            d_gnt  = d_win;
            mem_en = if_win || d_win;
            mem_we = d_win && d_we;
            if (if_win) begin
                mem_addr = if_addr;
            end else if (d_win) begin
                mem_addr = d_addr;
            end
            if (d_win && d_we) begin
                mem_wdata = d_wdata;
            end
            // RAM data is passed straight through in its valid cycle only.
            if (rd_done) begin
                if (owner) begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
            end
            halt = (if_req && !if_win) ||
                   (d_req && !d_win) ||
                   ((state == RD_WAIT) && (lat_cnt > 4'd1));
        end
    end

    // Next-state: track the outstanding read and the fetch starvation run.
    always_comb begin
        state_nxt      = state;
        lat_cnt_nxt    = lat_cnt;
        owner_nxt      = owner;
        starve_cnt_nxt = starve_cnt;

        if (state == RD_WAIT) begin
            lat_cnt_nxt = lat_cnt - 4'd1;
            if (rd_done) begin
                state_nxt = IDLE;
            end
        end

        // A read granted in the return cycle restarts the wait immediately.
        if (rd_grant) begin
            state_nxt   = RD_WAIT;
            lat_cnt_nxt = LAT_INIT;
            owner_nxt   = d_win;
        end

        // The run counts only while fetch is actually waiting; saturation is a guard only.
        if (!if_req || if_win) begin
            starve_cnt_nxt = 4'd0;
        end else if (d_win && (starve_cnt != 4'hF)) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
    end

    // State register; reset drops any outstanding read so no stale rvalid can follow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= 4'd0;
            starve_cnt <= 4'd0;
            owner      <= 1'b0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_cnt_nxt;
            starve_cnt <= starve_cnt_nxt;
            owner      <= owner_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (read latency 1 and 3) with identical request streams and compares
// every output each cycle against a cycle-accounting reference model and a RAM model.
// Requests are free-running: holding a request past its grant is simply a new request.
module tb_mem_port_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int LIM  = 4;
    localparam int NI   = 2;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          init_ram;

    logic          if_gnt    [NI];
    logic          if_rvalid [NI];
    logic [DW-1:0] if_rdata  [NI];
    logic          d_gnt     [NI];
    logic          d_rvalid  [NI];
    logic [DW-1:0] d_rdata   [NI];
    logic          mem_en    [NI];
    logic          mem_we    [NI];
    logic [AW-1:0] mem_addr  [NI];
    logic [DW-1:0] mem_wdata [NI];
    logic [DW-1:0] mem_rdata [NI];
    logic          halt      [NI];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT0), .STARVE_LIMIT(LIM)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .halt(halt[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT1), .STARVE_LIMIT(LIM)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .halt(halt[1])
    );

    function automatic logic [DW-1:0] ram_init(input int a);
        return 32'hA5A5_0000 ^ (32'(a) * 32'h0101_0107);
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    // RAM models: 256 words each, read data delayed through a pipe, garbage when no read.
    logic [DW-1:0] ram  [NI][256];
    logic [DW-1:0] pipe [NI][3];
    assign mem_rdata[0] = pipe[0][LAT0-1];
    assign mem_rdata[1] = pipe[1][LAT1-1];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            for (int k = 2; k > 0; k--) pipe[i][k] <= pipe[i][k-1];
            if (mem_en[i] && !mem_we[i]) pipe[i][0] <= ram[i][mem_addr[i][7:0]];
            else                         pipe[i][0] <= $urandom;
            if (mem_en[i] && mem_we[i])  ram[i][mem_addr[i][7:0]] <= mem_wdata[i];
        end
        if (init_ram) begin
            for (int i = 0; i < NI; i++)
                for (int a = 0; a < 256; a++) ram[i][a] <= ram_init(a);
        end
    end

    // Reference model: absolute cycle bookkeeping of the one outstanding read per port.
    int            cyc;
    int            errors;
    int            checks;
    bit            rd_pending [NI];
    int            rd_due     [NI];
    bit            rd_owner   [NI];
    logic [DW-1:0] rd_val     [NI];
    int            streak     [NI];
    logic [DW-1:0] shadow     [NI][256];

    task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lat=%0d cyc=%0d observed=%0h expected=%0h", tag, lat_of(i), cyc, obs, exp);
        end
    endtask

    task automatic eval_inst(input int i);
        bit            ret, free_port, iw, dw;
        logic [AW-1:0] e_addr;
        ret       = rd_pending[i] && (cyc == rd_due[i]);
        free_port = !rd_pending[i] || ret;
        iw        = rst_n && free_port && if_req && (!d_req || streak[i] == LIM);
        dw        = rst_n && free_port && d_req && !iw;
        e_addr    = iw ? if_addr : (dw ? d_addr : '0);

        chk("if_gnt",    i, 64'(if_gnt[i]),    64'(iw));
        chk("d_gnt",     i, 64'(d_gnt[i]),     64'(dw));
        chk("if_rvalid", i, 64'(if_rvalid[i]), 64'(rst_n && ret && !rd_owner[i]));
        chk("d_rvalid",  i, 64'(d_rvalid[i]),  64'(rst_n && ret && rd_owner[i]));
        chk("if_rdata",  i, 64'(if_rdata[i]),  (rst_n && ret && !rd_owner[i]) ? 64'(rd_val[i]) : 64'd0);
        chk("d_rdata",   i, 64'(d_rdata[i]),   (rst_n && ret && rd_owner[i]) ? 64'(rd_val[i]) : 64'd0);
        chk("mem_en",    i, 64'(mem_en[i]),    64'(iw || dw));
        chk("mem_we",    i, 64'(mem_we[i]),    64'(dw && d_we));
        chk("mem_addr",  i, 64'(mem_addr[i]),  64'(e_addr));
        // Write data is only defined for stores and for idle cycles.
        if (!(iw || (dw && !d_we)))
            chk("mem_wdata", i, 64'(mem_wdata[i]), (dw && d_we) ? 64'(d_wdata) : 64'd0);
        chk("halt", i, 64'(halt[i]),
            64'(rst_n && ((if_req && !iw) || (d_req && !dw) || (rd_pending[i] && !ret))));

        if (!rst_n) begin
            rd_pending[i] = 1'b0;
            streak[i]     = 0;
        end else begin
            if (ret) rd_pending[i] = 1'b0;
            if (iw || (dw && !d_we)) begin
                rd_pending[i] = 1'b1;
                rd_due[i]     = cyc + lat_of(i);
                rd_owner[i]   = dw;
                rd_val[i]     = shadow[i][e_addr[7:0]];
            end
            if (dw && d_we) shadow[i][d_addr[7:0]] = d_wdata;
            if (!if_req || iw) streak[i] = 0;
            else if (dw)       streak[i] = streak[i] + 1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NI; i++) eval_inst(i);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        cyc = 0; errors = 0; checks = 0;
        rst_n = 1'b0; init_ram = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < NI; i++) begin
            rd_pending[i] = 1'b0; rd_due[i] = 0; rd_owner[i] = 1'b0;
            rd_val[i] = '0; streak[i] = 0;
            for (int a = 0; a < 256; a++) shadow[i][a] = ram_init(a);
        end

        // Reset state
        repeat (3) step();
        init_ram = 1'b0;
        rst_n    = 1'b1;
        idle(2);

        // Single fetch read of a word holding 0xDEADBEEF
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 32'hDEAD_BEEF;
        step();
        idle(1);
        if_req = 1'b1; if_addr = 16'h0010;
        step();
        idle(5);

        // Simultaneous fetch and load: load first, fetch in the return cycle
        if_req = 1'b1; if_addr = 16'h0020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
        step();
        d_req = 1'b0;
        repeat (3) step();
        idle(5);

        // Sustained contention: fetch wins once after LIM load grants
        if_req = 1'b1; if_addr = 16'h0024;
        d_req = 1'b1; d_we = 1'b0;
        for (int n = 0; n < 24; n++) begin
            d_addr = 16'h0100 + 16'(n);
            step();
        end
        idle(5);

        // Back-to-back stores, then read them back
        for (int k = 0; k < 3; k++) begin
            d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200 + 16'(4 * k); d_wdata = 32'(k + 1);
            step();
        end
        idle(2);
        for (int k = 0; k < 3; k++) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200 + 16'(4 * k);
            step();
            idle(3);
        end

        // Reset while a read is outstanding, then a fresh read
        if_req = 1'b1; if_addr = 16'h0030;
        step();
        if_req = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1; if_req = 1'b1; if_addr = 16'h0034;
        step();
        idle(6);

        // Store raised and withdrawn while the port is busy
        if_req = 1'b1; if_addr = 16'h0040;
        step();
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 32'h1234_5678;
        step();
        idle(5);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = 16'($urandom);
            d_req   = ($urandom_range(0, 3) != 0);
            d_we    = ($urandom_range(0, 2) == 0);
            d_addr  = 16'($urandom);
            d_wdata = $urandom;
            step();
        end
        rst_n = 1'b1;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
